// File: rtl/spi_host_queue.sv
// SPI host byte queue: TX/RX FIFOs feeding an external shift engine, with chip-select sequencing.
// Optional interrupt output enabled by defining SPI_HOST_QUEUE_IRQ_EN.
module spi_host_queue #(
  parameter int DEPTH = 4
) (
  input  logic       clock_in,
  input  logic       rs,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       tx_full,
  output logic       rx_empty,
  output logic       rx_ovf,
  input  logic       clr_ovf,
  output logic [7:0] xfer_byte,
  output logic       xfer_start,
  input  logic       xfer_done,
  input  logic [7:0] xfer_rx,
  output logic       cs,
  output logic       irq
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_LAUNCH, ST_WAIT, ST_HOLD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          cs_q, cs_d, xfer_start_q, xfer_start_d, ovf_q, ovf_d;
  logic [7:0]    xfer_byte_q, xfer_byte_d;
  logic          tx_empty, rx_full, tx_push, tx_pop, rx_push, rx_pop, done_ok, ovf_set;

  assign tx_full  = (tx_cnt_q == CW'(DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // The TX FIFO is never empty in LAUNCH, so popping there needs no extra guard.
  assign tx_pop  = (state_q == ST_LAUNCH);
  assign tx_push = wr_en && (!tx_full || tx_pop);
  assign rx_pop  = rd_en && !rx_empty;
  assign done_ok = (state_q == ST_WAIT) && xfer_done;
  assign rx_push = done_ok && (!rx_full || rx_pop);
  assign ovf_set = done_ok && rx_full && !rx_pop;

  always_comb begin
    tx_wp_d  = tx_wp_q + AW'(tx_push);
    tx_rp_d  = tx_rp_q + AW'(tx_pop);
    rx_wp_d  = rx_wp_q + AW'(rx_push);
    rx_rp_d  = rx_rp_q + AW'(rx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    ovf_d    = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!tx_empty) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (xfer_done) state_d = tx_empty ? ST_HOLD : ST_LAUNCH;
      ST_HOLD:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Outputs are registered off the next state so they line up with the state they describe.
    cs_d         = (state_d == ST_IDLE);
    xfer_start_d = (state_d == ST_LAUNCH);
    xfer_byte_d  = (state_d == ST_LAUNCH) ? tx_mem_q[tx_rp_q] : xfer_byte_q;
  end

  always_ff @(posedge clock_in) begin
    if (rs) begin
      state_q      <= ST_IDLE;
      tx_wp_q      <= '0;
      tx_rp_q      <= '0;
      rx_wp_q      <= '0;
      rx_rp_q      <= '0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      cs_q         <= 1'b1;
      xfer_start_q <= 1'b0;
      xfer_byte_q  <= 8'h00;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_wp_q      <= tx_wp_d;
      tx_rp_q      <= tx_rp_d;
      rx_wp_q      <= rx_wp_d;
      rx_rp_q      <= rx_rp_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      cs_q         <= cs_d;
      xfer_start_q <= xfer_start_d;
      xfer_byte_q  <= xfer_byte_d;
      ovf_q        <= ovf_d;
    end
  end

  // Storage arrays hold data only; occupancy is tracked by the counters above.
  always_ff @(posedge clock_in) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= wr_data;
    if (rx_push) rx_mem_q[rx_wp_q] <= xfer_rx;
  end

  assign rd_data    = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
  assign rx_ovf     = ovf_q;
  assign cs         = cs_q;
  assign xfer_start = xfer_start_q;
  assign xfer_byte  = xfer_byte_q;

`ifdef SPI_HOST_QUEUE_IRQ_EN
  logic done_seen_q, done_seen_d, irq_q, irq_d;

  always_comb begin
    done_seen_d = done_ok ? 1'b1 : (rx_pop ? 1'b0 : done_seen_q);
    irq_d       = (rx_cnt_d != '0) || ovf_d ||
                  ((state_d == ST_IDLE) && (tx_cnt_d == '0) && done_seen_d);
  end

  always_ff @(posedge clock_in) begin
    if (rs) begin
      done_seen_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      done_seen_q <= done_seen_d;
      irq_q       <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_spi_host_queue.sv
// Scoreboard bench for spi_host_queue: stimulus queues expected launch/read bytes, a monitor checks them.
module tb_spi_host_queue;
  logic       clock_in = 1'b0;
  logic       rs = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       tx_full, rx_empty, rx_ovf;
  logic       clr_ovf = 1'b0;
  logic [7:0] xfer_byte;
  logic       xfer_start;
  logic       xfer_done = 1'b0;
  logic [7:0] xfer_rx = 8'h00;
  logic       cs, irq;

`ifdef SPI_HOST_QUEUE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  spi_host_queue #(.DEPTH(4)) dut (
    .clock_in(clock_in), .rs(rs), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .tx_full(tx_full), .rx_empty(rx_empty),
    .rx_ovf(rx_ovf), .clr_ovf(clr_ovf), .xfer_byte(xfer_byte), .xfer_start(xfer_start),
    .xfer_done(xfer_done), .xfer_rx(xfer_rx), .cs(cs), .irq(irq)
  );

  always #5 clock_in = ~clock_in;

  int         n_total = 0;
  int         n_pass  = 0;
  int         n_starts = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  bit         cs_track = 1'b0;
  bit         cs_bad   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Monitor: every launch and every accepted read is matched against the scoreboard.
  always @(negedge clock_in) begin
    if (xfer_start === 1'b1) begin
      n_starts++;
      if (exp_tx.size() == 0) begin
        n_total++;
        $display("FAIL launch: unexpected launch of %02h, expected none", xfer_byte);
      end else check("xfer_byte", xfer_byte, exp_tx.pop_front());
    end
    if (rd_en && rx_empty === 1'b0) begin
      if (exp_rx.size() == 0) begin
        n_total++;
        $display("FAIL rd_data: unexpected read of %02h, expected none", rd_data);
      end else check("rd_data", rd_data, exp_rx.pop_front());
    end
    if (cs_track && cs !== 1'b0) cs_bad = 1'b1;
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (xfer_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_total++;
      $display("FAIL start_timeout: got no launch, expected one within 100 cycles");
    end
  endtask

  task automatic respond(input logic [7:0] b, input int dly);
    repeat (dly) tick();
    xfer_done = 1'b1; xfer_rx = b;
    tick();
    xfer_done = 1'b0;
  endtask

  task automatic do_reset();
    rs = 1'b1;
    tick();
    rs = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    tick();
    do_reset();
    check("rst_cs", cs, 1);
    check("rst_start", xfer_start, 0);
    check("rst_byte", xfer_byte, 8'h00);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_ovf", rx_ovf, 0);
    check("rst_irq", irq, 0);
    check("rst_rd_data", rd_data, 8'h00);

    // Single byte: cs falls two cycles after the push, launch one cycle later.
    exp_tx.push_back(8'hA9);
    wr_en = 1'b1; wr_data = 8'hA9;
    tick();
    wr_en = 1'b0;
    check("a9_cs_c1", cs, 1);
    tick();
    check("a9_cs_c2", cs, 0);
    check("a9_start_c2", xfer_start, 0);
    tick();
    check("a9_start_c3", xfer_start, 1);
    tick();
    respond(8'h3C, 3);
    check("a9_hold_cs", cs, 0);
    check("a9_rx_empty", rx_empty, 0);
    check("a9_irq_set", irq, IRQ_ON);
    tick();
    check("a9_idle_cs", cs, 1);
    check("a9_irq_idle", irq, IRQ_ON);
    exp_rx.push_back(8'h3C);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("a9_rx_drained", rx_empty, 1);
    check("a9_irq_clear", irq, 0);

    // Three back-to-back transfers keep cs low throughout.
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33);
    push(8'h11); push(8'h22); push(8'h33);
    wait_start();
    cs_track = 1'b1;
    respond(8'h55, 16);
    wait_start();
    respond(8'h66, 16);
    wait_start();
    respond(8'h77, 16);
    cs_track = 1'b0;
    check("burst_cs_low", cs_bad, 0);
    check("burst_hold_cs", cs, 0);
    tick();
    check("burst_idle_cs", cs, 1);
    exp_rx.push_back(8'h55); exp_rx.push_back(8'h66); exp_rx.push_back(8'h77);
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    check("burst_rx_empty", rx_empty, 1);

    // TX full while the engine stalls, then five unread completions overflow RX.
    do_reset();
    base = n_starts;
    exp_tx.push_back(8'h01);
    push(8'h01);
    wait_start();
    tick();
    push(8'hB1); push(8'hB2); push(8'hB3);
    check("full_after_3", tx_full, 0);
    push(8'hB4);
    check("full_after_4", tx_full, 1);
    push(8'hB5);
    check("full_after_5", tx_full, 1);
    exp_tx.push_back(8'hB1); exp_tx.push_back(8'hB2);
    exp_tx.push_back(8'hB3); exp_tx.push_back(8'hB4);
    respond(8'hC0, 4);
    for (int k = 1; k < 5; k++) begin
      wait_start();
      respond(8'hC0 + 8'(k), 4);
    end
    check("ovf_set", rx_ovf, 1);
    check("ovf_irq", irq, IRQ_ON);
    repeat (10) tick();
    check("launch_count", n_starts - base, 5);
    check("tx_drained", tx_full, 0);
    check("ovf_sticky", rx_ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", rx_ovf, 0);
    for (int k = 0; k < 4; k++) exp_rx.push_back(8'hC0 + 8'(k));
    rd_en = 1'b1;
    repeat (4) tick();
    rd_en = 1'b0;
    check("ovf_rx_empty", rx_empty, 1);

    // Reset during WAIT aborts; a stray done afterwards is ignored.
    exp_tx.push_back(8'h5A);
    push(8'h5A); push(8'h6B);
    wait_start();
    tick(); tick();
    check("abort_cs_before", cs, 0);
    do_reset();
    base = n_starts;
    check("abort_cs", cs, 1);
    check("abort_rx_empty", rx_empty, 1);
    check("abort_tx_full", tx_full, 0);
    xfer_done = 1'b1; xfer_rx = 8'hEE;
    tick();
    xfer_done = 1'b0;
    repeat (5) tick();
    check("stray_rx_empty", rx_empty, 1);
    check("stray_cs", cs, 1);
    check("stray_no_launch", n_starts - base, 0);
    check("stray_irq", irq, 0);

    check("exp_tx_left", exp_tx.size(), 0);
    check("exp_rx_left", exp_rx.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
